// File: rtl/cv32e40p_pkg.sv
// Shared types and limits for the register-file write-back arbiter and its FIFO.
package cv32e40p_pkg;

    localparam int WB_MAX_ENQ    = 2;
    localparam int WB_MAX_DEQ    = 2;
    localparam int WB_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH = 32;

    // Layout of one queued write in the default configuration.
    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/cv32e40p_rf_wb_fifo.sv
// DEPTH-entry circular FIFO with two enqueue and two dequeue slots per cycle.
// Exposes the two oldest entries and a per-entry valid/address view for hazard decode.
module cv32e40p_rf_wb_fifo
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int CNT_W     = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  i_enq_n,
    input  logic [ADDR_WIDTH-1:0]       i_enq_addr_0,
    input  logic [DATA_WIDTH-1:0]       i_enq_data_0,
    input  logic [ADDR_WIDTH-1:0]       i_enq_addr_1,
    input  logic [DATA_WIDTH-1:0]       i_enq_data_1,
    input  logic [1:0]                  i_deq_n,
    output logic [CNT_W-1:0]            o_count,
    output logic [ADDR_WIDTH-1:0]       o_head_addr_0,
    output logic [DATA_WIDTH-1:0]       o_head_data_0,
    output logic [ADDR_WIDTH-1:0]       o_head_addr_1,
    output logic [DATA_WIDTH-1:0]       o_head_data_1,
    output logic [DEPTH-1:0]            o_entry_valid,
    output logic [DEPTH*ADDR_WIDTH-1:0] o_entry_addr
);

    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      w_wr_ptr_1;
    logic [PTR_W-1:0]      w_rd_ptr_1;
    logic [PTR_W-1:0]      w_offset;

    assign w_wr_ptr_1 = r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_1 = r_rd_ptr + PTR_W'(1);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_deq_n);
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_enq_n);
            r_count  <= r_count + CNT_W'(i_enq_n) - CNT_W'(i_deq_n);
        end
    end

    // NOTE: payload storage is deliberately not reset; validity comes only from the count.
    always_ff @(posedge clk) begin
        if (i_enq_n != 2'd0) begin
            r_addr[r_wr_ptr] <= i_enq_addr_0;
            r_data[r_wr_ptr] <= i_enq_data_0;
        end
        if (i_enq_n == 2'(WB_MAX_ENQ)) begin
            r_addr[w_wr_ptr_1] <= i_enq_addr_1;
            r_data[w_wr_ptr_1] <= i_enq_data_1;
        end
    end

    assign o_count       = r_count;
    assign o_head_addr_0 = r_addr[r_rd_ptr];
    assign o_head_data_0 = r_data[r_rd_ptr];
    assign o_head_addr_1 = r_addr[w_rd_ptr_1];
    assign o_head_data_1 = r_data[w_rd_ptr_1];

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        w_offset      = '0;
        o_entry_valid = '0;
        o_entry_addr  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset         = PTR_W'(i) - r_rd_ptr;
            o_entry_valid[i] = {1'b0, w_offset} < r_count;
            o_entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = r_addr[i];
        end
    end

endmodule

// File: rtl/cv32e40p_rf_wb_arbiter.sv
// Round-robin collector of producer results feeding the two RF write ports through an in-order FIFO.
// Optional CV32E40P_WB_BYPASS_EN: results granted into an empty FIFO are written in the same cycle.
module cv32e40p_rf_wb_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    output logic [NUM_SRC-1:0]            src_ready_o,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr_i,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data_i,
    output logic [ADDR_WIDTH-1:0]         waddr_a_o,
    output logic [DATA_WIDTH-1:0]         wdata_a_o,
    output logic                          we_a_o,
    output logic [ADDR_WIDTH-1:0]         waddr_b_o,
    output logic [DATA_WIDTH-1:0]         wdata_b_o,
    output logic                          we_b_o,
    output logic [2**ADDR_WIDTH-1:0]      pending_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int RR_W  = $clog2(NUM_SRC);

    logic [RR_W-1:0]            r_rr;
    logic [RR_W-1:0]            w_rr_next;
    logic [NUM_SRC-1:0]         w_grant;
    logic [1:0]                 w_n_grant;
    logic [1:0]                 w_max_grant;
    logic [CNT_W-1:0]           w_free;
    logic [1:0]                 w_n_cmt;
    logic [ADDR_WIDTH-1:0]      w_cmt_addr [WB_MAX_ENQ];
    logic [DATA_WIDTH-1:0]      w_cmt_data [WB_MAX_ENQ];
    logic [1:0]                 w_enq_n;
    logic [1:0]                 w_deq_n;
    logic                       w_bypass;
    logic [CNT_W-1:0]           w_count;
    logic [ADDR_WIDTH-1:0]      w_head_addr_0;
    logic [DATA_WIDTH-1:0]      w_head_data_0;
    logic [ADDR_WIDTH-1:0]      w_head_addr_1;
    logic [DATA_WIDTH-1:0]      w_head_data_1;
    logic [DEPTH-1:0]           w_entry_valid;
    logic [DEPTH*ADDR_WIDTH-1:0] w_entry_addr;

    assign w_free      = CNT_W'(DEPTH) - w_count;
    assign w_max_grant = (w_free >= CNT_W'(WB_MAX_ENQ)) ? 2'(WB_MAX_ENQ) : w_free[1:0];

    // Grants are issued oldest-first from the rr pointer; x0 targets are acked but dropped.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        int idx;
        w_grant   = '0;
        w_n_grant = '0;
        w_n_cmt   = '0;
        w_rr_next = r_rr;
        for (int j = 0; j < WB_MAX_ENQ; j++) begin
            w_cmt_addr[j] = '0;
            w_cmt_data[j] = '0;
        end
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_SRC) idx = idx - NUM_SRC;
            if (rst_n && src_valid_i[idx] && (w_n_grant < w_max_grant)) begin
                w_grant[idx] = 1'b1;
                w_n_grant    = w_n_grant + 2'd1;
                w_rr_next    = (idx == NUM_SRC - 1) ? '0 : RR_W'(idx + 1);
                if (src_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH] != '0) begin
                    w_cmt_addr[w_n_cmt[0]] = src_addr_i[idx*ADDR_WIDTH +: ADDR_WIDTH];
                    w_cmt_data[w_n_cmt[0]] = src_data_i[idx*DATA_WIDTH +: DATA_WIDTH];
                    w_n_cmt                = w_n_cmt + 2'd1;
                end
            end
        end
    end

    assign src_ready_o = w_grant;

`ifdef CV32E40P_WB_BYPASS_EN
    assign w_bypass = (w_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_enq_n = w_bypass ? 2'd0 : w_n_cmt;
    assign w_deq_n = (w_count >= CNT_W'(WB_MAX_DEQ)) ? 2'(WB_MAX_DEQ) : w_count[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr <= '0;
        end else if (w_n_grant != 2'd0) begin
            r_rr <= w_rr_next;
        end
    end

    cv32e40p_rf_wb_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_enq_n       (w_enq_n),
        .i_enq_addr_0  (w_cmt_addr[0]),
        .i_enq_data_0  (w_cmt_data[0]),
        .i_enq_addr_1  (w_cmt_addr[1]),
        .i_enq_data_1  (w_cmt_data[1]),
        .i_deq_n       (w_deq_n),
        .o_count       (w_count),
        .o_head_addr_0 (w_head_addr_0),
        .o_head_data_0 (w_head_data_0),
        .o_head_addr_1 (w_head_addr_1),
        .o_head_data_1 (w_head_data_1),
        .o_entry_valid (w_entry_valid),
        .o_entry_addr  (w_entry_addr)
    );

    // Port B always carries the younger entry so same-address pairs resolve in order.
    always_comb begin
        we_a_o    = 1'b0;
        waddr_a_o = '0;
        wdata_a_o = '0;
        we_b_o    = 1'b0;
        waddr_b_o = '0;
        wdata_b_o = '0;
        if (w_bypass) begin
            if (w_n_cmt >= 2'd1) begin
                we_a_o    = 1'b1;
                waddr_a_o = w_cmt_addr[0];
                wdata_a_o = w_cmt_data[0];
            end
            if (w_n_cmt == 2'd2) begin
                we_b_o    = 1'b1;
                waddr_b_o = w_cmt_addr[1];
                wdata_b_o = w_cmt_data[1];
            end
        end else begin
            if (w_count >= CNT_W'(1)) begin
                we_a_o    = 1'b1;
                waddr_a_o = w_head_addr_0;
                wdata_a_o = w_head_data_0;
            end
            if (w_count >= CNT_W'(2)) begin
                we_b_o    = 1'b1;
                waddr_b_o = w_head_addr_1;
                wdata_b_o = w_head_data_1;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i]) pending_o[w_entry_addr[i*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
        end
    end

endmodule

// File: tb/tb_cv32e40p_rf_wb_arbiter.sv
// Scenario bench for the write-back arbiter against a queue-based reference model.
module tb_cv32e40p_rf_wb_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NS    = 3;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready_o;
    logic [NS*AW-1:0]  src_addr;
    logic [NS*DW-1:0]  src_data;
    logic [AW-1:0]     waddr_a_o, waddr_b_o;
    logic [DW-1:0]     wdata_a_o, wdata_b_o;
    logic              we_a_o, we_b_o;
    logic [2**AW-1:0]  pending_o;

    // reference model state and per-cycle expectations
    ent_t              q[$];
    ent_t              grant_list[$];
    int                rr_m;
    int                new_rr;
    bit                bypass_now;
    logic [NS-1:0]     exp_ready;
    logic              exp_we_a, exp_we_b;
    logic [AW-1:0]     exp_wa_a, exp_wa_b;
    logic [DW-1:0]     exp_wd_a, exp_wd_b;
    logic [2**AW-1:0]  exp_pend;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cv32e40p_rf_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_SRC    (NS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_valid_i (src_valid),
        .src_ready_o (src_ready_o),
        .src_addr_i  (src_addr),
        .src_data_i  (src_data),
        .waddr_a_o   (waddr_a_o),
        .wdata_a_o   (wdata_a_o),
        .we_a_o      (we_a_o),
        .waddr_b_o   (waddr_b_o),
        .wdata_b_o   (wdata_b_o),
        .we_b_o      (we_b_o),
        .pending_o   (pending_o)
    );

    // Expected behaviour this cycle, from the queue contents and current inputs.
    task automatic model_eval();
        int   free, maxg, n, last, idx;
        ent_t e;
        ent_t view[$];
        free = DEPTH - q.size();
        maxg = (free < 2) ? free : 2;
        exp_ready = '0;
        n = 0;
        last = -1;
        grant_list.delete();
        for (int k = 0; k < NS; k++) begin
            idx = (rr_m + k) % NS;
            if (src_valid[idx] && n < maxg) begin
                exp_ready[idx] = 1'b1;
                n++;
                last = idx;
                e.a = src_addr[idx*AW +: AW];
                e.d = src_data[idx*DW +: DW];
                if (e.a != 0) grant_list.push_back(e);
            end
        end
        bypass_now = 1'b0;
`ifdef CV32E40P_WB_BYPASS_EN
        bypass_now = (q.size() == 0);
`endif
        if (bypass_now) view = grant_list;
        else view = q;
        exp_we_a = 1'b0; exp_wa_a = '0; exp_wd_a = '0;
        exp_we_b = 1'b0; exp_wa_b = '0; exp_wd_b = '0;
        if (view.size() >= 1) begin
            exp_we_a = 1'b1; exp_wa_a = view[0].a; exp_wd_a = view[0].d;
        end
        if (view.size() >= 2) begin
            exp_we_b = 1'b1; exp_wa_b = view[1].a; exp_wd_b = view[1].d;
        end
        exp_pend = '0;
        foreach (q[i]) exp_pend[q[i].a] = 1'b1;
        new_rr = (last >= 0) ? (last + 1) % NS : rr_m;
    endtask

    task automatic model_commit();
        int n_deq;
        if (!bypass_now) begin
            n_deq = (q.size() < 2) ? q.size() : 2;
            repeat (n_deq) void'(q.pop_front());
            foreach (grant_list[i]) q.push_back(grant_list[i]);
        end
        rr_m = new_rr;
    endtask

    task automatic settle();
        model_eval();
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i]        = v;
        src_addr[i*AW +: AW] = a;
        src_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_valid = '0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rr_m = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_src(0, 1'b1, 5'd1, 32'h11);
        set_src(1, 1'b1, 5'd2, 32'h22);
        set_src(2, 1'b1, 5'd3, 32'h33);
        #12;
        checks++; if (src_ready_o !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 000", src_ready_o); end
        checks++; if ({we_a_o, we_b_o} !== 2'b00) begin errors++; $display("FAIL reset_we: got %b expected 00", {we_a_o, we_b_o}); end
        checks++; if (pending_o !== '0) begin errors++; $display("FAIL reset_pending: got %h expected 0", pending_o); end
        checks++; if ({waddr_a_o, wdata_a_o} !== '0) begin errors++; $display("FAIL reset_port_a: got %h expected 0", {waddr_a_o, wdata_a_o}); end
        do_reset();
    endtask

    task automatic test_single();
        set_src(0, 1'b1, 5'd5, 32'hA5A5);
        settle();
        checks++; if (src_ready_o !== 3'b001) begin errors++; $display("FAIL single_ready: got %b expected 001", src_ready_o); end
        checks++; if (we_a_o !== exp_we_a) begin errors++; $display("FAIL single_we_a_c0: got %b expected %b", we_a_o, exp_we_a); end
        tick();
        src_valid = '0;
        settle();
        checks++; if (we_a_o !== exp_we_a || waddr_a_o !== exp_wa_a || wdata_a_o !== exp_wd_a) begin
            errors++; $display("FAIL single_port_a: got %b/%0d/%h expected %b/%0d/%h", we_a_o, waddr_a_o, wdata_a_o, exp_we_a, exp_wa_a, exp_wd_a); end
        checks++; if (we_b_o !== 1'b0) begin errors++; $display("FAIL single_we_b: got %b expected 0", we_b_o); end
        checks++; if (pending_o !== exp_pend) begin errors++; $display("FAIL single_pending: got %h expected %h", pending_o, exp_pend); end
        tick();
        settle();
        checks++; if (pending_o !== '0 || we_a_o !== 1'b0) begin errors++; $display("FAIL single_drained: got pend=%h we_a=%b expected 0/0", pending_o, we_a_o); end
        tick();
    endtask

    task automatic test_rr();
        do_reset();
        set_src(0, 1'b1, 5'd1, $urandom);
        set_src(1, 1'b1, 5'd2, $urandom);
        set_src(2, 1'b1, 5'd3, $urandom);
        settle();
        checks++; if (src_ready_o !== 3'b011) begin errors++; $display("FAIL rr_first: got %b expected 011", src_ready_o); end
        tick();
        settle();
        checks++; if (src_ready_o !== 3'b101) begin errors++; $display("FAIL rr_second: got %b expected 101", src_ready_o); end
        checks++; if (we_a_o !== exp_we_a || waddr_a_o !== exp_wa_a || waddr_b_o !== exp_wa_b) begin
            errors++; $display("FAIL rr_ports: got %b/%0d/%0d expected %b/%0d/%0d", we_a_o, waddr_a_o, waddr_b_o, exp_we_a, exp_wa_a, exp_wa_b); end
        tick();
        src_valid = '0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (pending_o !== exp_pend || we_a_o !== exp_we_a || we_b_o !== exp_we_b) begin
                errors++; $display("FAIL rr_drain: got %h/%b%b expected %h/%b%b", pending_o, we_a_o, we_b_o, exp_pend, exp_we_a, exp_we_b); end
            tick();
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        src_valid = '0;
        set_src(0, 1'b1, 5'd7, 32'd1);
        set_src(1, 1'b1, 5'd7, 32'd2);
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if ({we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o} !==
                          {exp_we_a, exp_wa_a, exp_wd_a, exp_we_b, exp_wa_b, exp_wd_b}) begin
                errors++; $display("FAIL same_addr: got A=%b/%0d/%h B=%b/%0d/%h expected A=%b/%0d/%h B=%b/%0d/%h",
                    we_a_o, waddr_a_o, wdata_a_o, we_b_o, waddr_b_o, wdata_b_o, exp_we_a, exp_wa_a, exp_wd_a, exp_we_b, exp_wa_b, exp_wd_b); end
            checks++; if (we_a_o && we_b_o && wdata_b_o !== 32'd2) begin errors++; $display("FAIL same_addr_b_young: got %h expected 2", wdata_b_o); end
            tick();
            src_valid = '0;
        end
    endtask

    task automatic test_pressure();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NS; i++) set_src(i, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            settle();
            checks++; if (src_ready_o !== exp_ready) begin errors++; $display("FAIL pressure_ready: got %b expected %b", src_ready_o, exp_ready); end
            checks++; if (pending_o !== exp_pend) begin errors++; $display("FAIL pressure_pending: got %h expected %h", pending_o, exp_pend); end
            checks++; if (wdata_a_o !== exp_wd_a || wdata_b_o !== exp_wd_b) begin
                errors++; $display("FAIL pressure_data: got %h/%h expected %h/%h", wdata_a_o, wdata_b_o, exp_wd_a, exp_wd_b); end
            tick();
        end
        src_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_x0();
        do_reset();
        set_src(0, 1'b1, 5'd0, 32'hFFFF);
        settle();
        checks++; if (src_ready_o !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b expected 001", src_ready_o); end
        checks++; if (we_a_o !== 1'b0) begin errors++; $display("FAIL x0_we_c0: got %b expected 0", we_a_o); end
        tick();
        src_valid = '0;
        settle();
        checks++; if (we_a_o !== 1'b0 || we_b_o !== 1'b0) begin errors++; $display("FAIL x0_we_c1: got %b%b expected 00", we_a_o, we_b_o); end
        checks++; if (pending_o !== '0) begin errors++; $display("FAIL x0_pending: got %h expected 0", pending_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_src(0, 1'b1, 5'd9, $urandom);
        set_src(1, 1'b1, 5'd10, $urandom);
        set_src(2, 1'b1, 5'd11, $urandom);
        settle();
        tick();
        settle();
        checks++; if (pending_o !== exp_pend) begin errors++; $display("FAIL mid_pending_pre: got %h expected %h", pending_o, exp_pend); end
        rst_n = 1'b0;
        #1;
        checks++; if ({we_a_o, we_b_o} !== 2'b00 || pending_o !== '0 || src_ready_o !== '0) begin
            errors++; $display("FAIL mid_reset: got we=%b%b pend=%h rdy=%b expected 00/0/000", we_a_o, we_b_o, pending_o, src_ready_o); end
        src_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        rr_m = 0;
        settle();
        checks++; if (we_a_o !== 1'b0 || pending_o !== '0) begin errors++; $display("FAIL mid_after: got we_a=%b pend=%h expected 0/0", we_a_o, pending_o); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < NS; i++) set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            settle();
            checks++; if (src_ready_o !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", c, src_ready_o, exp_ready); end
            checks++; if (we_a_o !== exp_we_a || waddr_a_o !== exp_wa_a || wdata_a_o !== exp_wd_a) begin
                errors++; $display("FAIL rand_port_a c%0d: got %b/%0d/%h expected %b/%0d/%h", c, we_a_o, waddr_a_o, wdata_a_o, exp_we_a, exp_wa_a, exp_wd_a); end
            checks++; if (we_b_o !== exp_we_b || waddr_b_o !== exp_wa_b || wdata_b_o !== exp_wd_b) begin
                errors++; $display("FAIL rand_port_b c%0d: got %b/%0d/%h expected %b/%0d/%h", c, we_b_o, waddr_b_o, wdata_b_o, exp_we_b, exp_wa_b, exp_wd_b); end
            checks++; if (pending_o !== exp_pend) begin errors++; $display("FAIL rand_pending c%0d: got %h expected %h", c, pending_o, exp_pend); end
            tick();
        end
        src_valid = '0;
    endtask

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        rr_m      = 0;
        test_reset();
        test_single();
        test_rr();
        test_same_addr();
        test_pressure();
        test_x0();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
